// File: rtl/video_timing_pkg.sv
// ----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the raster timing generator:
//   - timing constants for the 640x480@60 and 1280x720@60 modes
//   - vid_ctrl_t, the bundle of control strobes carried through the delay line
//   - h_total / v_total helpers that derive the full line/frame length
// ----------------------------------------------------------------------------
package video_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // 1280x720@60, 74.25 MHz pixel clock
    localparam int unsigned HD_H_ACTIVE = 1280;
    localparam int unsigned HD_H_FP     = 110;
    localparam int unsigned HD_H_SYNC   = 40;
    localparam int unsigned HD_H_BP     = 220;
    localparam int unsigned HD_V_ACTIVE = 720;
    localparam int unsigned HD_V_FP     = 5;
    localparam int unsigned HD_V_SYNC   = 5;
    localparam int unsigned HD_V_BP     = 20;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic frame_start;
        logic line_start;
    } vid_ctrl_t;

    localparam int unsigned CTRL_W = $bits(vid_ctrl_t);

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// ----------------------------------------------------------------------------
// video_timing_if
// Raster timing bundle from the timing generator to its consumers
// (pixel generators and the TMDS encoder).
//   pos_x/pos_y  : current raster coordinates (undelayed)
//   hsync/vsync  : sync strobes at their configured polarity (delayed)
//   de           : active-video enable (delayed)
//   frame_start  : pulse at pixel (0,0) (delayed)
//   line_start   : pulse at h=0 of every line (delayed)
//   frame_cnt    : frames completed, free-running 16-bit
// master = the generator, slave = a consumer.
// ----------------------------------------------------------------------------
interface video_timing_if #(
    parameter int unsigned CW = 12
) ();
    logic [CW-1:0] pos_x;
    logic [CW-1:0] pos_y;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          frame_start;
    logic          line_start;
    logic [15:0]   frame_cnt;

    modport master (
        output pos_x, pos_y, hsync, vsync, de, frame_start, line_start, frame_cnt
    );

    modport slave (
        input pos_x, pos_y, hsync, vsync, de, frame_start, line_start, frame_cnt
    );
endinterface

// File: rtl/sync_delay_line.sv
// ----------------------------------------------------------------------------
// sync_delay_line
// DEPTH-stage shift register for the video control strobes. Advances only
// when i_ce is high; synchronous active-low reset loads every tap with
// i_rst_val so sync outputs come out of reset at their inactive level.
// DEPTH = 0 is a straight wire.
//   i_pix_clk  : pixel clock
//   i_rst_n    : synchronous active-low reset
//   i_ce       : pixel enable
//   i_din      : control word in (vid_ctrl_t)
//   i_rst_val  : value loaded into every tap on reset
//   o_dout     : control word out, DEPTH enabled cycles later
// ----------------------------------------------------------------------------
module sync_delay_line
    import video_timing_pkg::*;
#(
    parameter int unsigned WIDTH = CTRL_W,
    parameter int unsigned DEPTH = 0
) (
    input  logic             i_pix_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_din,
    input  logic [WIDTH-1:0] i_rst_val,
    output logic [WIDTH-1:0] o_dout
);

    if (DEPTH == 0) begin : g_direct
        logic w_unused;
        assign w_unused = ^{i_pix_clk, i_rst_n, i_ce, i_rst_val};
        assign o_dout   = i_din;
    end else begin : g_taps
        logic [WIDTH-1:0] r_taps [DEPTH];

        always_ff @(posedge i_pix_clk) begin
            if (!i_rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_taps[i] <= i_rst_val;
                end
            end else if (i_ce) begin
                r_taps[0] <= i_din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    r_taps[i] <= r_taps[i-1];
                end
            end
        end

        assign o_dout = r_taps[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator: horizontal/vertical counters, registered
// coordinates, sync/de strobes, frame/line start pulses and a frame counter.
// The control strobes pass through a PIPE_DLY-deep delay line so they line up
// with rgb computed downstream from the (undelayed) coordinates.
//   i_pix_clk : pixel clock
//   i_rst_n   : synchronous active-low reset
//   i_ce      : pixel enable; low freezes all state
//   o_vid     : video_timing_if master (pos_x/pos_y, hsync, vsync, de,
//               frame_start, line_start, frame_cnt)
// ----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_DLY = 0,
    parameter int unsigned CW       = 12
) (
    input  logic           i_pix_clk,
    input  logic           i_rst_n,
    input  logic           i_ce,
    video_timing_if.master o_vid
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
    begin : g_err_zero
        $error("video_timing_gen: porch and sync widths must be non-zero");
    end
    if (64'(H_TOTAL) >= (64'd1 << CW) || 64'(V_TOTAL) >= (64'd1 << CW)) begin : g_err_cw
        $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (PIPE_DLY > 15) begin : g_err_dly
        $error("video_timing_gen: PIPE_DLY must be 0..15");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Syncs reset to their inactive level, everything else to 0.
    localparam vid_ctrl_t CTRL_RST = vid_ctrl_t'{
        hsync:       ~HS_POL,
        vsync:       ~VS_POL,
        de:          1'b0,
        frame_start: 1'b0,
        line_start:  1'b0
    };

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [15:0]   r_frame_cnt;
    logic [CW-1:0] r_pos_x;
    logic [CW-1:0] r_pos_y;
    vid_ctrl_t     r_ctrl;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic [15:0]   w_fc_next;
    vid_ctrl_t     w_ctrl;
    vid_ctrl_t     w_ctrl_dly;

    // Counter next-state and the control word decoded from the current count.
    always_comb begin
        w_h_wrap  = (r_h_cnt == H_LAST);
        w_v_wrap  = (r_v_cnt == V_LAST);
        w_h_next  = w_h_wrap ? '0 : r_h_cnt + 1'b1;
        w_v_next  = r_v_cnt;
        w_fc_next = r_frame_cnt;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_cnt + 1'b1;
            if (w_v_wrap) begin
                w_fc_next = r_frame_cnt + 16'd1;
            end
        end

        w_ctrl             = CTRL_RST;
        w_ctrl.de          = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_ctrl.hsync       = ((r_h_cnt >= HS_START) && (r_h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        // v_cnt only moves on the h wrap, so vsync is naturally line-granular.
        w_ctrl.vsync       = ((r_v_cnt >= VS_START) && (r_v_cnt < VS_END)) ? VS_POL : ~VS_POL;
        w_ctrl.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_ctrl.line_start  = (r_h_cnt == '0);
    end

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_ctrl      <= CTRL_RST;
        end else if (i_ce) begin
            r_h_cnt     <= w_h_next;
            r_v_cnt     <= w_v_next;
            r_frame_cnt <= w_fc_next;
            r_pos_x     <= r_h_cnt;
            r_pos_y     <= r_v_cnt;
            r_ctrl      <= w_ctrl;
        end
    end

    sync_delay_line #(
        .WIDTH (CTRL_W),
        .DEPTH (PIPE_DLY)
    ) u_sync_delay_line (
        .i_pix_clk (i_pix_clk),
        .i_rst_n   (i_rst_n),
        .i_ce      (i_ce),
        .i_din     (r_ctrl),
        .i_rst_val (CTRL_RST),
        .o_dout    (w_ctrl_dly)
    );

    assign o_vid.pos_x       = r_pos_x;
    assign o_vid.pos_y       = r_pos_y;
    assign o_vid.frame_cnt   = r_frame_cnt;
    assign o_vid.hsync       = w_ctrl_dly.hsync;
    assign o_vid.vsync       = w_ctrl_dly.vsync;
    assign o_vid.de          = w_ctrl_dly.de;
    assign o_vid.frame_start = w_ctrl_dly.frame_start;
    assign o_vid.line_start  = w_ctrl_dly.line_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_timing_gen
// Three generators share clock, reset and ce:
//   dut0 : default 640x480 mode, PIPE_DLY=0
//   dut1 : tiny 25x15 raster, PIPE_DLY=0
//   dut2 : same tiny raster, PIPE_DLY=3, active-high syncs
// The reference model derives every output from k, the number of enabled
// clock edges since reset was released.
// ----------------------------------------------------------------------------
module tb_video_timing_gen;
    import video_timing_pkg::*;

    typedef struct packed {
        logic [11:0] px;
        logic [11:0] py;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } obs_t;

    localparam int HA  [3] = '{640, 16, 16};
    localparam int HF  [3] = '{16, 2, 2};
    localparam int HS  [3] = '{96, 3, 3};
    localparam int HB  [3] = '{48, 4, 4};
    localparam int VA  [3] = '{480, 8, 8};
    localparam int VF  [3] = '{10, 2, 2};
    localparam int VSW [3] = '{2, 2, 2};
    localparam int VB  [3] = '{33, 3, 3};
    localparam bit HP  [3] = '{1'b0, 1'b0, 1'b1};
    localparam bit VP  [3] = '{1'b0, 1'b0, 1'b1};
    localparam int DL  [3] = '{0, 0, 3};
    localparam int SMALL_FRAME = 25 * 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    int unsigned k = 0;
    int n_checks = 0;
    int n_err = 0;
    obs_t obs [3];

    always #5 clk = ~clk;

    // Enabled-edge count since reset; the model's only notion of time.
    always @(posedge clk) begin
        if (!rst_n) k <= 0;
        else if (ce) k <= k + 1;
    end

    video_timing_if #(.CW(12)) vif0 ();
    video_timing_if #(.CW(12)) vif1 ();
    video_timing_if #(.CW(12)) vif2 ();

    video_timing_gen u_dut0 (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .i_ce      (ce),
        .o_vid     (vif0)
    );

    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .HS_POL (1'b0), .VS_POL (1'b0), .PIPE_DLY (0), .CW (12)
    ) u_dut1 (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .i_ce      (ce),
        .o_vid     (vif1)
    );

    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .HS_POL (1'b1), .VS_POL (1'b1), .PIPE_DLY (3), .CW (12)
    ) u_dut2 (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .i_ce      (ce),
        .o_vid     (vif2)
    );

    assign obs[0] = {vif0.pos_x, vif0.pos_y, vif0.hsync, vif0.vsync, vif0.de,
                     vif0.frame_start, vif0.line_start, vif0.frame_cnt};
    assign obs[1] = {vif1.pos_x, vif1.pos_y, vif1.hsync, vif1.vsync, vif1.de,
                     vif1.frame_start, vif1.line_start, vif1.frame_cnt};
    assign obs[2] = {vif2.pos_x, vif2.pos_y, vif2.hsync, vif2.vsync, vif2.de,
                     vif2.frame_start, vif2.line_start, vif2.frame_cnt};

    // After kk enabled edges, coordinates show raster position kk-1 and the
    // controls show raster position kk-1-delay (reset values before that).
    function automatic obs_t model(input int d, input int unsigned kk);
        int ht, vt, t, c, h, v;
        obs_t o;
        ht = HA[d] + HF[d] + HS[d] + HB[d];
        vt = VA[d] + VF[d] + VSW[d] + VB[d];
        o = '0;
        o.hs = ~HP[d];
        o.vs = ~VP[d];
        if (kk == 0) return o;
        t = int'(kk) - 1;
        o.px = 12'(t % ht);
        o.py = 12'((t / ht) % vt);
        o.fc = 16'((int'(kk) / (ht * vt)) % 65536);
        c = t - DL[d];
        if (c >= 0) begin
            h = c % ht;
            v = (c / ht) % vt;
            o.de = (h < HA[d]) && (v < VA[d]);
            o.hs = (h >= HA[d] + HF[d] && h < HA[d] + HF[d] + HS[d]) ? HP[d] : ~HP[d];
            o.vs = (v >= VA[d] + VF[d] && v < VA[d] + VF[d] + VSW[d]) ? VP[d] : ~VP[d];
            o.fs = (h == 0) && (v == 0);
            o.ls = (h == 0);
        end
        return o;
    endfunction

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0;
        ce    = 1'b0;
        repeat (2) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            e = model(d, 0);
            n_checks++;
            if (obs[d] !== e) begin
                n_err++;
                $display("FAIL reset dut%0d got=%h exp=%h", d, obs[d], e);
            end
        end
    endtask

    // First line of the default mode plus many tiny lines; hsync window check.
    task automatic test_line0();
        obs_t e;
        int hs_low, hs_first;
        hs_low   = 0;
        hs_first = -1;
        rst_n = 1'b1;
        ce    = 1'b1;
        for (int s = 1; s <= 820; s++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                e = model(d, k);
                n_checks++;
                if (obs[d] !== e) begin
                    n_err++;
                    $display("FAIL line0 dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
                end
            end
            if (s <= 800 && vif0.hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = s;
            end
        end
        n_checks++;
        if (hs_low != 96) begin
            n_err++;
            $display("FAIL hsync_width got=%0d exp=96", hs_low);
        end
        n_checks++;
        if (hs_first != 657) begin
            n_err++;
            $display("FAIL hsync_start got=%0d exp=657", hs_first);
        end
    endtask

    // Full tiny frames, frame_cnt roll-over and vsync width (2 lines = 50 cycles).
    task automatic test_frame();
        obs_t e;
        int vs_low;
        vs_low = 0;
        ce = 1'b1;
        for (int s = 0; s < 800; s++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                e = model(d, k);
                n_checks++;
                if (obs[d] !== e) begin
                    n_err++;
                    $display("FAIL frame dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
                end
            end
            if (k > 2 * SMALL_FRAME && k <= 3 * SMALL_FRAME && vif1.vsync === 1'b0) vs_low++;
        end
        n_checks++;
        if (vs_low != 50) begin
            n_err++;
            $display("FAIL vsync_width got=%0d exp=50", vs_low);
        end
    endtask

    task automatic test_ce_random();
        obs_t e;
        for (int s = 0; s < 1500; s++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                e = model(d, k);
                n_checks++;
                if (obs[d] !== e) begin
                    n_err++;
                    $display("FAIL ce_rand dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
                end
            end
            ce = 1'($urandom % 2);
        end
        ce = 1'b1;
    endtask

    // One reset edge (with ce low) mid-frame, then a clean restart.
    task automatic test_reset_mid();
        obs_t e;
        int guard;
        guard = 0;
        ce = 1'b1;
        @(negedge clk);
        while ((k % SMALL_FRAME) != 136 && guard < 2 * SMALL_FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if ((k % SMALL_FRAME) != 136) begin
            n_err++;
            $display("FAIL reset_mid_wait got=%0d exp=136", k % SMALL_FRAME);
        end
        rst_n = 1'b0;
        ce    = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            e = model(d, 0);
            n_checks++;
            if (obs[d] !== e) begin
                n_err++;
                $display("FAIL reset_mid dut%0d got=%h exp=%h", d, obs[d], e);
            end
        end
        rst_n = 1'b1;
        ce    = 1'b1;
        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                e = model(d, k);
                n_checks++;
                if (obs[d] !== e) begin
                    n_err++;
                    $display("FAIL restart dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line0();
        test_frame();
        test_ce_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
